multiword_adder_ctrl: RTL and testbench

MULTIWORD_ADDER_CTRL -- requirements
Module: multiword_adder_ctrl

---
 rtl/multiword_adder_ctrl.sv | 111 +++++++++++
 tb/tb_multiword_adder_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multiword_adder_ctrl.sv
// Multi-word add/subtract controller: processes one N-bit word per cycle
// through a single ripple-carry adder and publishes the full result at completion.
module multiword_adder_ctrl #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 abort,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 c_in,
  output logic                 ready,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 c_out
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [N*WORDS-1:0]   r_a;
  logic [N*WORDS-1:0]   r_b;
  logic                 r_sub;
  logic [IW-1:0]        r_idx;
  logic                 r_carry;
  logic [N*WORDS-1:0]   r_work;
  logic [N*WORDS-1:0]   r_sum;
  logic                 r_cOut;

  logic [N-1:0]         w_aWord;
  logic [N-1:0]         w_bWord;
  logic [N-1:0]         w_res;
  logic                 w_cy;
  logic [N*WORDS-1:0]   w_workNext;
  logic                 w_accept;
  logic                 w_lastWord;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_lastWord = (r_idx == LAST_IDX);
  assign ready      = (r_state == IDLE);
  assign done       = (r_state == DONE);
  assign sum        = r_sum;
  assign c_out      = r_cOut;

  // One word slice per cycle; subtraction is A + ~B with the carry preloaded to 1.
  always_comb begin
    w_aWord    = r_a[r_idx*N +: N];
    w_bWord    = r_sub ? ~r_b[r_idx*N +: N] : r_b[r_idx*N +: N];
    {w_cy, w_res} = {1'b0, w_aWord} + {1'b0, w_bWord} + (N+1)'(r_carry);
    w_workNext = r_work;
    w_workNext[r_idx*N +: N] = w_res;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (start) w_stateNext = RUN;
      RUN: begin
        if (abort)           w_stateNext = IDLE;
        else if (w_lastWord) w_stateNext = DONE;
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Result registers only move on a non-aborted final word, so partial sums stay hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cOut  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= sub;
      r_idx   <= '0;
      r_carry <= sub ? 1'b1 : c_in;
    end else if ((r_state == RUN) && !abort) begin
      r_work  <= w_workNext;
      r_carry <= w_cy;
      r_idx   <= r_idx + 1'b1;
      if (w_lastWord) begin
        r_sum  <= w_workNext;
        r_cOut <= w_cy;
      end
    end
  end

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Directed self-checking bench for multiword_adder_ctrl at N=8, WORDS=4.
module tb_multiword_adder_ctrl;

  localparam int N     = 8;
  localparam int WORDS = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic          abort;
  logic [31:0]   a;
  logic [31:0]   b;
  logic          c_in;
  logic          ready;
  logic          done;
  logic [31:0]   sum;
  logic          c_out;

  int nChecks;
  int nPass;
  int doneCount;

  multiword_adder_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .abort (abort),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    if (obs !== expv)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    else
      nPass++;
  endtask

  // Issue one operation, wait (bounded) for done, and check latency, result and return to ready.
  task automatic applyStimulus(input string tag, input logic s, input logic [31:0] va,
                               input logic [31:0] vb, input logic ci,
                               input logic [31:0] expSum, input logic expCout);
    int lat;
    lat = -1;
    @(negedge clk);
    checkOutput({tag, "_readyBefore"}, 32'(ready), 32'd1);
    sub = s; a = va; b = vb; c_in = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(WORDS));
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_cout"}, 32'(c_out), 32'(expCout));
    @(posedge clk);
    #1;
    checkOutput({tag, "_doneLow"}, 32'(done), 32'd0);
    checkOutput({tag, "_readyAfter"}, 32'(ready), 32'd1);
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; abort = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    #12;
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", sum, 32'h0);
    checkOutput("rst_cout", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("cin_only", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0001, 1'b0);
    applyStimulus("carry_w0", 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    applyStimulus("carry_mid", 1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0);
    applyStimulus("all_ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    applyStimulus("mixed_add", 1'b0, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0);
    applyStimulus("sub_7m5", 1'b1, 32'd7, 32'd5, 1'b0, 32'h0000_0002, 1'b1);
    applyStimulus("sub_5m7", 1'b1, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0);

    // Start held high through every RUN and DONE cycle with shifting operands.
    doneCount = 0;
    @(negedge clk);
    sub = 1'b0; a = 32'h0000_0010; b = 32'h0000_0020; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= WORDS + 1; k++) begin
      #1;
      a = 32'h1111_1111 * k; b = 32'h0F0F_0F0F + k; sub = k[0]; c_in = 1'b1;
      @(posedge clk);
      #1;
      if (done) begin
        doneCount++;
        checkOutput("busy_start_sum", sum, 32'h0000_0030);
        checkOutput("busy_start_cout", 32'(c_out), 32'd0);
      end
    end
    start = 1'b0;
    checkOutput("busy_start_ready", 32'(ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("busy_start_doneCount", 32'(doneCount), 32'd1);

    // Abort on the second RUN cycle leaves the previous result in place.
    applyStimulus("pre_abort", 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    doneCount = 0;
    @(negedge clk);
    sub = 1'b0; a = 32'hAAAA_AAAA; b = 32'h5555_5555; c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_sum", sum, 32'h0000_0100);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("abort_doneCount", 32'(doneCount), 32'd0);
    checkOutput("abort_sumLater", sum, 32'h0000_0100);

    // Abort while idle must not disturb a following operation.
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("idle_abort_ready", 32'(ready), 32'd1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    sub = 1'b0; a = 32'h0102_0304; b = 32'h0101_0101; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_sum", sum, 32'h0);
    checkOutput("midrst_cout", 32'(c_out), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst", 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
